// File: rtl/sclkfifoarb.sv
// Round-robin write arbiter feeding a single sclkfiforeg write port through a one-entry output stage.
// Optional burst locking is built when SCLKFIFOARB_LOCK_EN is defined.
module sclkfifoarb #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDXW  = 2
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic [NREQ-1:0]       req_wen,
  input  logic [NREQ*WIDTH-1:0] req_wdata,
  input  logic [NREQ-1:0]       req_wlast,
  output logic [NREQ-1:0]       req_wfull,
  output logic                  fifo_wen,
  output logic [WIDTH-1:0]      fifo_wdata,
  output logic [IDXW-1:0]       fifo_wsrc,
  input  logic                  fifo_wfull
);

  logic             r_ovalid;
  logic [WIDTH-1:0] r_odata;
  logic [IDXW-1:0]  r_osrc;
  logic [IDXW-1:0]  r_rr_ptr;

  logic             w_slot;
  logic             w_accept;
  logic             w_gnt_vld;
  logic [IDXW-1:0]  w_gnt;
  logic [IDXW-1:0]  w_gnt_nxt;
  logic [WIDTH-1:0] w_gnt_data;
  logic [2*NREQ-1:0] w_req_rot;
  logic [IDXW:0]    w_sum;
  logic [WIDTH-1:0] w_wdata [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign w_wdata[i]   = req_wdata[i*WIDTH +: WIDTH];
    assign req_wfull[i] = !(w_accept && (w_gnt == IDXW'(i)));
  end

`ifdef SCLKFIFOARB_LOCK_EN
  logic            r_locked;
  logic [IDXW-1:0] r_lock_idx;
`else
  logic w_unused_wlast;
  assign w_unused_wlast = ^req_wlast;
`endif

  assign w_slot    = !r_ovalid || !fifo_wfull;
  assign w_req_rot = {req_wen, req_wen} >> r_rr_ptr;

  // First requester at or after rr_ptr wins; index wrapped back into 0..NREQ-1.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_sum     = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_gnt_vld && w_req_rot[k]) begin
        w_gnt_vld = 1'b1;
        w_sum     = {1'b0, r_rr_ptr} + (IDXW+1)'(k);
        if (w_sum >= (IDXW+1)'(NREQ)) w_sum = w_sum - (IDXW+1)'(NREQ);
        w_gnt     = w_sum[IDXW-1:0];
      end
    end
`ifdef SCLKFIFOARB_LOCK_EN
    if (r_locked) begin
      w_gnt     = r_lock_idx;
      w_gnt_vld = |(req_wen & (NREQ'(1) << r_lock_idx));
    end
`endif
  end

  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (w_gnt == IDXW'(i)) w_gnt_data = w_wdata[i];
  end

  assign w_accept  = w_slot && w_gnt_vld && !srst;
  assign w_gnt_nxt = (w_gnt == IDXW'(NREQ-1)) ? '0 : w_gnt + IDXW'(1);

  always_ff @(posedge clk) begin
    if (srst) begin
      r_ovalid <= 1'b0;
      r_odata  <= '0;
      r_osrc   <= '0;
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_ovalid <= 1'b1;
      r_odata  <= w_gnt_data;
      r_osrc   <= w_gnt;
      r_rr_ptr <= w_gnt_nxt;
    end else if (!fifo_wfull) begin
      r_ovalid <= 1'b0;
    end
  end

`ifdef SCLKFIFOARB_LOCK_EN
  // A non-last word opens a burst; the last word of the locked producer closes it.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_locked   <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_accept) begin
      if (r_locked) begin
        if (|(req_wlast & (NREQ'(1) << r_lock_idx))) r_locked <= 1'b0;
      end else if (!(|(req_wlast & (NREQ'(1) << w_gnt)))) begin
        r_locked   <= 1'b1;
        r_lock_idx <= w_gnt;
      end
    end
  end
`endif

  assign fifo_wen   = r_ovalid;
  assign fifo_wdata = r_odata;
  assign fifo_wsrc  = r_osrc;

endmodule

// File: tb/tb_sclkfifoarb.sv
// Directed bench for sclkfifoarb: reset, streaming round-robin, single/dual requesters,
// back-pressure hold, reset mid-transfer, and burst locking when SCLKFIFOARB_LOCK_EN is set.
module tb_sclkfifoarb;
  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int IDXW  = 2;

  logic                  clk = 1'b0;
  logic                  srst;
  logic [NREQ-1:0]       req_wen;
  logic [NREQ*WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]       req_wlast;
  logic [NREQ-1:0]       req_wfull;
  logic                  fifo_wen;
  logic [WIDTH-1:0]      fifo_wdata;
  logic [IDXW-1:0]       fifo_wsrc;
  logic                  fifo_wfull;

  int n_chk = 0;
  int n_err = 0;
  int cnt [NREQ];

  sclkfifoarb #(.WIDTH(WIDTH), .NREQ(NREQ), .IDXW(IDXW)) dut (
    .clk(clk), .srst(srst), .req_wen(req_wen), .req_wdata(req_wdata),
    .req_wlast(req_wlast), .req_wfull(req_wfull), .fifo_wen(fifo_wen),
    .fifo_wdata(fifo_wdata), .fifo_wsrc(fifo_wsrc), .fifo_wfull(fifo_wfull)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_data();
    for (int i = 0; i < NREQ; i++)
      req_wdata[i*WIDTH +: WIDTH] = 32'(i*256 + cnt[i]);
  endtask

  // Expected stage contents after one accept from producer g (bench-side counters).
  task automatic expect_word(input string tag, input int g);
    chk({tag, "_wen"}, 32'(fifo_wen), 32'd1);
    chk({tag, "_src"}, 32'(fifo_wsrc), 32'(g));
    chk({tag, "_data"}, fifo_wdata, 32'(g*256 + cnt[g]));
    cnt[g]++;
    drive_data();
  endtask

  initial begin
    int order [4];
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    srst = 1'b1; req_wen = '1; req_wlast = '0; fifo_wfull = 1'b0;
    drive_data();

    // Reset held three cycles with everyone requesting
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_wen", 32'(fifo_wen), 32'd0);
      chk("rst_data", fifo_wdata, 32'd0);
      chk("rst_src", 32'(fifo_wsrc), 32'd0);
      chk("rst_wfull", 32'(req_wfull), 32'hF);
    end
    srst = 1'b0;
    #1;

    // All four streaming: 0,1,2,3,0,1,2,3 one word per cycle
    for (int n = 0; n < 8; n++) begin
      chk("rr_wfull", 32'(req_wfull), 32'(4'hF ^ (4'h1 << (n % 4))));
      step();
      expect_word("rr", n % 4);
    end

    // Only producer 2: always granted, pointer parks at 3
    req_wen = 4'b0100;
    #1;
    for (int n = 0; n < 3; n++) begin
      chk("p2_wfull", 32'(req_wfull), 32'hB);
      step();
      expect_word("p2", 2);
      chk("p2_ptr", 32'(dut.r_rr_ptr), 32'd3);
    end

    // Producers 0 and 2 alternate starting with 0
    req_wen = 4'b0101;
    order = '{0, 2, 0, 2};
    for (int n = 0; n < 4; n++) begin
      step();
      expect_word("p02", order[n]);
    end

    // Load 0x105 from producer 1, then back-pressure for five cycles
    req_wen = 4'b0010;
    req_wdata[1*WIDTH +: WIDTH] = 32'h105;
    step();
    chk("bp_load_src", 32'(fifo_wsrc), 32'd1);
    chk("bp_load_data", fifo_wdata, 32'h105);
    fifo_wfull = 1'b1;
    req_wen = 4'b1111;
    drive_data();
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_wfull", 32'(req_wfull), 32'hF);
      step();
      chk("bp_wen", 32'(fifo_wen), 32'd1);
      chk("bp_src", 32'(fifo_wsrc), 32'd1);
      chk("bp_data", fifo_wdata, 32'h105);
    end
    // Release: pointer still at 2, consume and accept in the same cycle
    fifo_wfull = 1'b0;
    #1;
    chk("bp_rel_wfull", 32'(req_wfull), 32'hB);
    step();
    expect_word("bp_rel", 2);

    // Reset while the stage holds a word
    req_wen = '0;
    fifo_wfull = 1'b1;
    srst = 1'b1;
    #1;
    chk("srst_wfull", 32'(req_wfull), 32'hF);
    step();
    chk("srst_wen", 32'(fifo_wen), 32'd0);
    chk("srst_ptr", 32'(dut.r_rr_ptr), 32'd0);
    chk("srst_data", fifo_wdata, 32'd0);
    srst = 1'b0;
    fifo_wfull = 1'b0;
    step();
    chk("srst_nowrite", 32'(fifo_wen), 32'd0);

    // One word from producer 0, then no requests: stage drains
    req_wen = 4'b0001;
    step();
    expect_word("drain_ld", 0);
    req_wen = '0;
    #1;
    chk("idle_wfull", 32'(req_wfull), 32'hF);
    step();
    chk("drain_wen", 32'(fifo_wen), 32'd0);

`ifdef SCLKFIFOARB_LOCK_EN
    // Producer 1 burst of four while 0 and 3 request; then 3, then 0
    req_wen = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      req_wlast = (k == 3) ? 4'b0010 : 4'b0000;
      #1;
      chk("lock_wfull", 32'(req_wfull), 32'hD);
      step();
      expect_word("lock_burst", 1);
    end
    req_wlast = 4'b1001;
    step();
    expect_word("lock_after3", 3);
    step();
    expect_word("lock_after0", 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
